// File: rtl/act_pwl_pipe.sv
// Two-stage piecewise-linear activation (sigmoid / tanh / ReLU / bypass) with valid/ready flow control.
// Optional macro ACT_PWL_SAT_FLAG_EN adds out_sat, set when the sigmoid/tanh core hits its saturation segment.
module act_pwl_pipe #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned FRAC  = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
`ifdef ACT_PWL_SAT_FLAG_EN
  ,
  output logic             out_sat
`endif
);

  localparam int unsigned MW = WIDTH + 1;

  localparam logic [MW-1:0] ONE  = MW'(1) << FRAC;
  localparam logic [MW-1:0] HALF = ONE >> 1;
  localparam logic [MW-1:0] C0   = MW'(5) << (FRAC - 3);
  localparam logic [MW-1:0] C1   = MW'(27) << (FRAC - 5);
  localparam logic [MW-1:0] T1   = ONE;
  localparam logic [MW-1:0] T2   = MW'(19) << (FRAC - 3);
  localparam logic [MW-1:0] T3   = MW'(5) << FRAC;

  localparam logic [1:0] M_SIG  = 2'b00;
  localparam logic [1:0] M_TANH = 2'b01;
  localparam logic [1:0] M_RELU = 2'b10;
  localparam logic [1:0] M_BYP  = 2'b11;

  logic             s1_valid;
  logic [1:0]       s1_mode;
  logic             s1_sign;
  logic [MW-1:0]    s1_mag;
  logic [1:0]       s1_seg;
  logic             s1_en;
  logic             s2_en;

  logic [MW-1:0]    ext;
  logic [MW-1:0]    mag0;
  logic             sign0;
  logic [1:0]       seg0;

  logic [MW-1:0]    core;
  logic [MW-1:0]    sgm;
  logic [WIDTH-1:0] y;

  assign s2_en    = !out_valid || out_ready;
  assign s1_en    = !s1_valid || s2_en;
  assign in_ready = s1_en;

  // Magnitude is unsigned and one bit wider, so |most negative| (and |2x| for tanh) is exact.
  always_comb begin
    ext   = (in_mode == M_TANH) ? {in_data, 1'b0} : {in_data[WIDTH-1], in_data};
    sign0 = ext[MW-1];
    mag0  = sign0 ? (~ext + MW'(1)) : ext;
    if (mag0 < T1)      seg0 = 2'd0;
    else if (mag0 < T2) seg0 = 2'd1;
    else if (mag0 < T3) seg0 = 2'd2;
    else                seg0 = 2'd3;
  end

  // Stage-2 result: sigmoid core, sign fold, then per-mode output mapping.
  always_comb begin
    core = ONE;
    case (s1_seg)
      2'd0:    core = (s1_mag >> 2) + HALF;
      2'd1:    core = (s1_mag >> 3) + C0;
      2'd2:    core = (s1_mag >> 5) + C1;
      default: core = ONE;
    endcase
    sgm = s1_sign ? (ONE - core) : core;
    y   = WIDTH'(sgm);
    case (s1_mode)
      M_SIG:   y = WIDTH'(sgm);
      M_TANH:  y = WIDTH'((sgm << 1) - ONE);
      M_RELU:  y = s1_sign ? '0 : WIDTH'(s1_mag);
      M_BYP:   y = WIDTH'(s1_sign ? (~s1_mag + MW'(1)) : s1_mag);
      default: y = WIDTH'(sgm);
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_mode   <= 2'b00;
      s1_sign   <= 1'b0;
      s1_mag    <= '0;
      s1_seg    <= 2'd0;
      out_valid <= 1'b0;
      out_data  <= '0;
`ifdef ACT_PWL_SAT_FLAG_EN
      out_sat   <= 1'b0;
`endif
    end else begin
      if (s1_en) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_mode <= in_mode;
          s1_sign <= sign0;
          s1_mag  <= mag0;
          s1_seg  <= seg0;
        end
      end
      if (s2_en) begin
        out_valid <= s1_valid;
        if (s1_valid) begin
          out_data <= y;
`ifdef ACT_PWL_SAT_FLAG_EN
          out_sat  <= (s1_seg == 2'd3) && !s1_mode[1];
`endif
        end
      end
    end
  end

endmodule
